apb_master_bridge: RTL and testbench

- Single-outstanding command-to-APB master that drives the register-file APB slaves in this subsystem.
- Accepts one read or write request on a valid/ready command port and sequences the APB SETUP and ACCESS phases.
- Waits for PREADY, with a watchdog timeout.
- Returns read data and an error flag on a valid/ready response port.

---
 rtl/apb_master_bridge_pkg.sv | 22 ++
 rtl/apb_master_bridge_if.sv | 39 +++
 rtl/apb_master_bridge_timeout_cnt.sv | 44 ++++
 rtl/apb_master_bridge.sv | 148 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared types for the command-to-APB master bridge: FSM states, word alignment
// and the captured command, whose field widths match the downstream slaves.
package apb_master_bridge_pkg;

  localparam int APB_ADDR_WIDTH      = 4;
  localparam int APB_DATA_WIDTH      = 32;
  localparam int APB_WORD_ALIGN_BITS = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signals of the bridge; the master modport is the
// bridge's own view, the slave modport is the view of whatever surrounds it.
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master_bridge_timeout_cnt.sv
// Saturating ACCESS-phase watchdog; expired_o flags the last permitted wait
// cycle so the bridge leaves ACCESS after exactly LIMIT cycles. LIMIT=0 disables it.
module apb_master_bridge_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  if (LIMIT == 0) begin : g_off
    logic unused;
    assign unused    = ^{clk_i, rst_i, clear_i, enable_i};
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int             CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (enable_i && (cnt_q != MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired_o = enable_i && (cnt_q >= LAST);
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB master: one request in, one SETUP/ACCESS
// transfer out, one response back. All APB and response outputs are registered.
//
//   state  | meaning
//   IDLE   | cmd_ready high, waiting for a request
//   SETUP  | PSEL high, PENABLE low, one cycle
//   ACCESS | PSEL and PENABLE high, waiting for PREADY or the watchdog
//   RESP   | rsp_valid high, holding rdata/err until rsp_ready
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_master_bridge_if.master bus
);

  apb_state_e            state_q, state_d;
  apb_cmd_t              cmd_q, cmd_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic tmo_clear;
  logic tmo_enable;
  logic tmo_expired;
  logic cmd_aligned;

  assign cmd_aligned = (bus.cmd_addr[APB_WORD_ALIGN_BITS-1:0] == '0);
  assign tmo_enable  = (state_q == ACCESS) && !bus.PREADY;
  assign tmo_clear   = (state_d != ACCESS);

  apb_master_bridge_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (PCLK),
    .rst_i     (PRESET),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    cmd_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid) begin
          cmd_ready_d = 1'b0;
          if (cmd_aligned) begin
            state_d     = SETUP;
            cmd_d.write = bus.cmd_write;
            cmd_d.addr  = APB_ADDR_WIDTH'(bus.cmd_addr);
            cmd_d.wdata = APB_DATA_WIDTH'(bus.cmd_wdata);
            psel_d      = 1'b1;
          end else begin
            // misaligned requests never reach the bus
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = cmd_q.write ? '0 : DATA_WIDTH'(bus.PRDATA);
          rsp_err_d   = 1'b0;
        end else if (tmo_expired) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = cmd_q.write;
  assign bus.PADDR     = ADDR_WIDTH'(cmd_q.addr);
  assign bus.PWDATA    = DATA_WIDTH'(cmd_q.wdata);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a 4-register APB slave with programmable wait
// states, directed phase/timing checks and a scoreboard fed by a word-array model.
module tb_apb_master_bridge;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic PCLK;
  logic PRESET;

  apb_master_bridge_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH     (4),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // APB slave: four word registers, PREADY after slv_wait low ACCESS cycles
  logic [31:0] slv_mem [4];
  int          slv_wait = 0;
  bit          slv_dead = 1'b0;
  int          acc_cnt  = 0;

  assign bus.PREADY = !slv_dead && (acc_cnt >= slv_wait);
  assign bus.PRDATA = slv_mem[bus.PADDR[3:2]];

  always @(posedge PCLK) begin
    if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
      if (bus.PREADY) begin
        acc_cnt <= 0;
        if (bus.PWRITE) slv_mem[bus.PADDR[3:2]] <= bus.PWDATA;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  // reference model and scoreboard
  logic [31:0] mdl [4];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_exp  = 0;
  int          n_rsp  = 0;
  int          rsp_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit          mon_en = 1'b0;

  initial begin
    exp_t e;
    bus.rsp_ready = 1'b1;
    forever begin
      @(negedge PCLK);
      case (rsp_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
      if (mon_en) begin
        checks++;
        if (bus.PENABLE === 1'b1 && bus.PSEL !== 1'b1) begin
          errors++;
          $display("FAIL penable_without_psel got PSEL=%b PENABLE=%b required PSEL=1", bus.PSEL, bus.PENABLE);
        end
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp got rdata=%h err=%b required no response", bus.rsp_rdata, bus.rsp_err);
          end else begin
            e = exp_q.pop_front();
            n_rsp++;
            if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
              errors++;
              $display("FAIL rsp got rdata=%h err=%b required rdata=%h err=%b",
                       bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  // drive one command; returns 1ns after the accepting edge
  task automatic send(input bit w, input logic [3:0] a, input logic [31:0] d);
    int guard = 0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (bus.cmd_ready !== 1'b1 && guard < 200) begin
      @(negedge PCLK);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept got cmd_ready=%b required 1 within 200 cycles", bus.cmd_ready);
    end
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic issue(input bit w, input logic [3:0] a, input logic [31:0] d,
                       input bit dead, input bit keep);
    exp_t e;
    if (keep) begin
      if (a[1:0] != 2'b00 || dead) begin
        e.rdata = 32'h0;
        e.err   = 1'b1;
      end else if (w) begin
        mdl[a[3:2]] = d;
        e.rdata = 32'h0;
        e.err   = 1'b0;
      end else begin
        e.rdata = mdl[a[3:2]];
        e.err   = 1'b0;
      end
      exp_q.push_back(e);
      n_exp++;
    end
    send(w, a, d);
  endtask

  task automatic drain();
    int g = 0;
    do begin
      @(negedge PCLK);
      g++;
    end while (!(exp_q.size() == 0 && bus.cmd_ready === 1'b1) && g < 500);
    checks++;
    if (g >= 500) begin
      errors++;
      $display("FAIL drain got pending=%0d required 0 within 500 cycles", exp_q.size());
    end
  endtask

  task automatic count_penable(output int pen, output bit seen);
    pen  = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge PCLK);
      if (bus.PENABLE === 1'b1) pen++;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
  endtask

  initial begin
    int  pen;
    bit  seen;
    logic [3:0] a;
    bit  w;

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_psel",      32'(bus.PSEL), 32'd0);
    chk("rst_penable",   32'(bus.PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp",       {bus.rsp_rdata[30:0], bus.rsp_err}, 32'd0);
    chk("rst_apb_out",   {bus.PWDATA[26:0], bus.PADDR, bus.PWRITE}, 32'd0);
    PRESET = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 4; i++) issue(1'b1, 4'(i * 4), $urandom, 1'b0, 1'b1);
    drain();

    // write then read
    issue(1'b1, 4'h4, 32'hDEADBEEF, 1'b0, 1'b1);
    issue(1'b0, 4'h4, 32'h0, 1'b0, 1'b1);
    drain();

    // phase timing
    issue(1'b0, 4'h4, 32'h0, 1'b0, 1'b1);
    @(negedge PCLK);
    chk("setup_phase", {30'd0, bus.PSEL, bus.PENABLE}, 32'b10);
    chk("setup_paddr", 32'(bus.PADDR), 32'h4);
    @(negedge PCLK);
    chk("access_phase", {30'd0, bus.PSEL, bus.PENABLE}, 32'b11);
    chk("access_paddr", 32'(bus.PADDR), 32'h4);
    @(negedge PCLK);
    chk("resp_phase", {29'd0, bus.rsp_valid, bus.PSEL, bus.PENABLE}, 32'b100);
    drain();

    // misaligned
    issue(1'b0, 4'h6, 32'h0, 1'b0, 1'b1);
    @(negedge PCLK);
    chk("misal_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.PSEL}, 32'b110);
    @(negedge PCLK);
    chk("misal_psel", 32'(bus.PSEL), 32'd0);
    drain();

    // wait states
    issue(1'b1, 4'h8, 32'h12345678, 1'b0, 1'b1);
    drain();
    slv_wait = 3;
    issue(1'b0, 4'h8, 32'h0, 1'b0, 1'b1);
    count_penable(pen, seen);
    chk("wait_rsp_seen", 32'(seen), 32'd1);
    chk("wait_penable_cycles", 32'(pen), 32'd4);
    drain();
    slv_wait = 0;

    // timeout, then a normal transfer
    slv_dead = 1'b1;
    issue(1'b0, 4'h0, 32'h0, 1'b1, 1'b1);
    count_penable(pen, seen);
    chk("tmo_rsp_seen", 32'(seen), 32'd1);
    chk("tmo_penable_cycles", 32'(pen), 32'd16);
    chk("tmo_psel", 32'(bus.PSEL), 32'd0);
    drain();
    slv_dead = 1'b0;
    issue(1'b1, 4'h0, 32'hA5A55A5A, 1'b0, 1'b1);
    issue(1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    drain();

    // response backpressure
    rsp_mode = 2;
    issue(1'b0, 4'h4, 32'h0, 1'b0, 1'b1);
    count_penable(pen, seen);
    chk("bp_rsp_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk("bp_hold_valid", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'b10);
      chk("bp_hold_rdata", bus.rsp_rdata, mdl[1]);
    end
    rsp_mode = 0;
    drain();

    // reset during ACCESS drops the transfer silently
    slv_dead = 1'b1;
    issue(1'b1, 4'hC, $urandom, 1'b1, 1'b0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_mid_access", {30'd0, bus.PSEL, bus.PENABLE}, 32'b11);
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    chk("rst_mid_apb", {30'd0, bus.PSEL, bus.PENABLE}, 32'b00);
    chk("rst_mid_hs", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'b01);
    @(negedge PCLK);
    PRESET = 1'b0;
    slv_dead = 1'b0;
    repeat (5) @(negedge PCLK);
    issue(1'b0, 4'hC, 32'h0, 1'b0, 1'b1);
    drain();

    // randomized traffic with random wait states and response backpressure
    rsp_mode = 1;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      a[3:2] = 2'($urandom_range(0, 3));
      a[1:0] = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(1, 3)) : 2'b00;
      slv_wait = $urandom_range(0, 3);
      issue(w, a, $urandom, 1'b0, 1'b1);
    end
    drain();
    rsp_mode = 0;
    slv_wait = 0;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("rsp_count", 32'(n_rsp), 32'(n_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
